// File: rtl/sample_frame_assembler.sv
// Packs little-endian USB FIFO bytes into multi-channel audio frames
// for the I2S transmitter, with per-frame size/justify/sign config.
module sample_frame_assembler #(
  parameter int N_CHANNELS = 2,
  parameter int MAX_BYTES  = 4,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     sample_size,
  input  logic                           justify,
  input  logic                           sign_ext,
  input  logic                           flush,
  output logic [N_CHANNELS*OUT_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           cfg_error
);

  localparam int BW = 8 * MAX_BYTES;
  localparam logic [1:0] MAX_M1 = 2'(MAX_BYTES - 1);
  localparam logic [2:0] LAST_CH = 3'(N_CHANNELS - 1);

  logic [1:0] byte_cnt;
  logic [2:0] ch_cnt;
  logic [1:0] size_q;
  logic       just_q;
  logic       sext_q;

  logic [BW-1:0] buf_q [N_CHANNELS];
  logic [BW-1:0] buf_d [N_CHANNELS];

  logic       first;
  logic       last;
  logic       accept;
  logic       bad_size;
  logic [1:0] size_raw;
  logic [1:0] size_eff;
  logic       just_eff;
  logic       sext_eff;

  logic [N_CHANNELS*OUT_WIDTH-1:0] frame;

  function automatic logic [OUT_WIDTH-1:0] fmt(
    input logic [BW-1:0] raw,
    input logic [1:0]    nbm1,
    input logic          just,
    input logic          sext
  );
    int w;
    logic [OUT_WIDTH-1:0] mask;
    logic [OUT_WIDTH-1:0] val;
    logic sign;
    w    = 8 * (int'(nbm1) + 1);
    mask = ~({OUT_WIDTH{1'b1}} << w);
    val  = OUT_WIDTH'(raw) & mask;
    // mask & ~(mask >> 1) isolates bit w-1
    sign = |(val & ~(mask >> 1));
    if (just)
      return val << (OUT_WIDTH - w);
    else if (sext && sign)
      return val | ~mask;
    else
      return val;
  endfunction

  // First byte of a frame uses live config; later bytes the latched copy
  always_comb begin
    first    = (byte_cnt == '0) && (ch_cnt == '0);
    size_raw = first ? sample_size : size_q;
    bad_size = size_raw > MAX_M1;
    size_eff = bad_size ? MAX_M1 : size_raw;
    just_eff = first ? justify : just_q;
    sext_eff = first ? sign_ext : sext_q;
    last     = (byte_cnt == size_eff) && (ch_cnt == LAST_CH);
    in_ready = !flush && !(last && out_valid && !out_ready);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    frame = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      buf_d[c] = buf_q[c];
      for (int j = 0; j < MAX_BYTES; j++) begin
        if (ch_cnt == 3'(c) && byte_cnt == 2'(j))
          buf_d[c][8*j +: 8] = in_data;
      end
      frame[c*OUT_WIDTH +: OUT_WIDTH] =
        fmt(buf_d[c], size_eff, just_eff, sext_eff);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt  <= '0;
      ch_cnt    <= '0;
      size_q    <= '0;
      just_q    <= 1'b0;
      sext_q    <= 1'b0;
      cfg_error <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int c = 0; c < N_CHANNELS; c++)
        buf_q[c] <= '0;
    end else begin
      if (flush) begin
        byte_cnt <= '0;
        ch_cnt   <= '0;
        for (int c = 0; c < N_CHANNELS; c++)
          buf_q[c] <= '0;
      end else if (accept) begin
        if (first) begin
          size_q <= size_eff;
          just_q <= justify;
          sext_q <= sign_ext;
          if (bad_size)
            cfg_error <= 1'b1;
        end
        if (last) begin
          byte_cnt <= '0;
          ch_cnt   <= '0;
          for (int c = 0; c < N_CHANNELS; c++)
            buf_q[c] <= '0;
        end else begin
          for (int c = 0; c < N_CHANNELS; c++)
            buf_q[c] <= buf_d[c];
          if (byte_cnt == size_eff) begin
            byte_cnt <= '0;
            ch_cnt   <= ch_cnt + 3'd1;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
      end

      if (accept && last) begin
        out_data  <= frame;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sample_frame_assembler.md
Name: sample_frame_assembler

Overview:
Assembles little-endian bytes from the USB receive FIFO into complete multi-channel audio frames (one sample per channel) for the I2S transmitter. Supports 8/16/24/32-bit sample sizes, LSB- or MSB-justified output, and optional sign extension. Uses a valid/ready handshake on both sides, so FIFO underrun and I2S backpressure stall cleanly without losing data.

Parameters:
N_CHANNELS, 2, samples per frame; channel 0 arrives first (interleaved L, R, ...); legal range 1..8
MAX_BYTES, 4, largest supported sample size in bytes; legal range 1..4
OUT_WIDTH, 32, width of each output channel word; must be >= 8*MAX_BYTES

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
in_data  in  8  byte from USB FIFO
in_valid  in  1  in_data holds a valid byte
in_ready  out  1  block accepts in_data on this edge
sample_size  in  2  0=8-bit, 1=16-bit, 2=24-bit, 3=32-bit
justify  in  1  0=LSB-aligned, 1=MSB-aligned
sign_ext  in  1  sign-extend when LSB-aligned
flush  in  1  synchronous discard of a partial frame
out_data  out  N_CHANNELS*OUT_WIDTH  channel k at [k*OUT_WIDTH +: OUT_WIDTH]
out_valid  out  1  out_data holds a complete frame
out_ready  in  1  consumer takes frame on this edge
cfg_error  out  1  sticky: an illegal sample_size was latched

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, cfg_error=0. Byte counter, channel counter and assembly buffer = 0. Reset mid-frame discards all partial data.
- Byte transfer: occurs when in_valid && in_ready at posedge. Output transfer: occurs when out_valid && out_ready.
- Config latch: sample_size, justify and sign_ext are captured when byte 0 of channel 0 is accepted. They hold for the whole frame; mid-frame changes are ignored.
- Byte count nb = sample_size+1.
  - If nb > MAX_BYTES, use nb = MAX_BYTES and set cfg_error (sticky until rst).
- Assembly:
  - Byte b of channel c is written into buffer[c][8b+7:8b].
  - The byte counter wraps at nb-1 and advances the channel counter.
  - The channel counter wraps at N_CHANNELS-1, which completes the frame.
- in_ready = 1, except when the next byte completes the frame and out_valid=1 && out_ready=0. In that case in_ready = 0. in_ready depends combinationally on out_ready only.
- Frame completion: on the edge that accepts the last byte:
  - all channels are formatted into out_data;
  - out_valid=1 from the next cycle, so latency is 1 cycle after the last byte;
  - counters return to 0, and the next frame may start on the following cycle.
  - A simultaneous output transfer and completion in the same edge loads the new frame, and out_valid stays 1.
- Output holding: out_valid and out_data hold stable until out_ready. If no new frame completes, out_valid drops on the transfer edge.
- Formatting, with raw value R of width W = 8*nb:
  - justify=0, sign_ext=0: zero-extend R to OUT_WIDTH.
  - justify=0, sign_ext=1: replicate R[W-1] into the upper bits.
  - justify=1: R placed in the top W bits, low bits 0; sign_ext ignored.
- flush:
  - When high at an edge, counters and the assembly buffer clear, and any byte presented that cycle is dropped (in_ready=0 while flush=1).
  - The output register and out_valid are unaffected.
  - flush with no partial frame has no effect.
- in_valid=0 mid-frame: state holds indefinitely; no timeout.

Test Plan:
- Defaults, size=1, justify=0, sign_ext=1; bytes 34 12 CD AB, out_ready=1 → one cycle after byte AB: out_valid=1, ch0=0x00001234, ch1=0xFFFFABCD.
- size=2, justify=1; bytes 56 34 12 BC 9A 78 → ch0=0x12345600, ch1=0x789ABC00; sign_ext toggled mid-frame has no effect.
- Backpressure: out_ready=0, two back-to-back 8-bit frames (01 02, 03 04):
  - in_ready drops before byte 04;
  - out_data holds 0x01/0x02;
  - one cycle of out_ready=1 loads 0x03/0x04 with out_valid continuous.
- flush after bytes 11 22 33 (16-bit), then bytes 44 55 66 77 → frame ch0=0x00005544, ch1=0x00007766; bytes 11..33 never appear.
- Async rst asserted mid-frame between clock edges → out_valid, out_data and cfg_error clear immediately; the next 4 bytes form a fresh frame.
- MAX_BYTES=2, size=3 → cfg_error=1 sticky; 2 bytes per channel used; bytes 01 80 02 00 with sign_ext=1 → ch0=0xFFFF8001, ch1=0x00000002.
